// File: rtl/shiftrows_col_feeder_if.sv
// Bus bundle for shiftrows_col_feeder: the 128-bit state input handshake
// plus the serialised per-column output toward the mix stage.
interface shiftrows_col_feeder_if;
  logic [127:0] in_state;
  logic         in_control;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   A;
  logic [7:0]   B;
  logic [7:0]   C;
  logic [7:0]   D;
  logic         control;
  logic         col_valid;
  logic         col_ready;
  logic [1:0]   col_idx;
  logic         col_last;

  modport master (
    input  in_state, in_control, in_valid, col_ready,
    output in_ready, A, B, C, D, control, col_valid, col_idx, col_last
  );

  modport slave (
    output in_state, in_control, in_valid, col_ready,
    input  in_ready, A, B, C, D, control, col_valid, col_idx, col_last
  );
endinterface

// File: rtl/shiftrows_col_feeder.sv
// Applies (Inv)ShiftRows to a 128-bit AES state and streams it out as four
// handshaked 32-bit columns with the mode bit held alongside.
//
// state | meaning
// IDLE  | no state buffered, in_ready high
// SEND  | buffered state being emitted column by column
module shiftrows_col_feeder (
  input  logic                          clk,
  input  logic                          reset,
  shiftrows_col_feeder_if.master        bus
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t       state_q, state_d;
  logic [127:0] buf_q, buf_d;
  logic [31:0]  col_q, col_d;
  logic [1:0]   idx_q, idx_d;
  logic         ctrl_q, ctrl_d;
  logic         valid_q, valid_d;
  logic         last_q, last_d;
  logic [127:0] shifted;
  logic         accept;

  // Byte k = s(k mod 4, k div 4) at [127-8k -: 8]; column offsets wrap mod 4.
  function automatic logic [127:0] shift_state(input logic [127:0] s, input logic enc);
    logic [127:0] o;
    logic [1:0]   src;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = enc ? 2'(c + r) : 2'(c - r);
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*int'(src)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] column_of(input logic [127:0] s, input logic [1:0] idx);
    return s[127-32*int'(idx) -: 32];
  endfunction

  assign shifted      = shift_state(bus.in_state, bus.in_control);
  assign bus.in_ready = ~reset & ((state_q == IDLE) |
                                  ((state_q == SEND) & last_q & bus.col_ready));
  assign accept       = bus.in_valid & bus.in_ready;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    col_d   = col_q;
    idx_d   = idx_q;
    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SEND;
          buf_d   = shifted;
          col_d   = column_of(shifted, 2'd0);
          idx_d   = 2'd0;
          ctrl_d  = bus.in_control;
          valid_d = 1'b1;
          last_d  = 1'b0;
        end
      end
      SEND: begin
        if (bus.col_ready) begin
          if (!last_q) begin
            idx_d  = idx_q + 2'd1;
            col_d  = column_of(buf_q, idx_q + 2'd1);
            last_d = (idx_q == 2'd2);
          end else if (accept) begin
            // back-to-back: next state's column 0 follows with no bubble
            buf_d   = shifted;
            col_d   = column_of(shifted, 2'd0);
            idx_d   = 2'd0;
            ctrl_d  = bus.in_control;
            valid_d = 1'b1;
            last_d  = 1'b0;
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            idx_d   = 2'd0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      buf_q   <= '0;
      col_q   <= '0;
      idx_q   <= '0;
      ctrl_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      col_q   <= col_d;
      idx_q   <= idx_d;
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign bus.A         = col_q[31:24];
  assign bus.B         = col_q[23:16];
  assign bus.C         = col_q[15:8];
  assign bus.D         = col_q[7:0];
  assign bus.control   = ctrl_q;
  assign bus.col_valid = valid_q;
  assign bus.col_idx   = idx_q;
  assign bus.col_last  = last_q;

endmodule

// File: tb/tb_shiftrows_col_feeder.sv
// Bench for shiftrows_col_feeder: known-answer table, hand-written corner
// sequences, then randomized traffic against an array-based reference.
module tb_shiftrows_col_feeder;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  shiftrows_col_feeder_if bus();
  shiftrows_col_feeder dut (.clk(clk), .reset(reset), .bus(bus));

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [127:0] st;
    logic         ctl;
    logic [127:0] cols;
  } vec_t;

  typedef struct packed {
    logic [31:0] col;
    logic [1:0]  idx;
    logic        last;
    logic        ctrl;
  } exp_t;

  vec_t tbl[4];
  exp_t q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: view the state as a 4x4 byte matrix m[row][col] and rotate rows.
  function automatic logic [127:0] ref_shift(input logic [127:0] s, input logic enc);
    logic [7:0]   m [4][4];
    logic [127:0] o;
    int           src;
    for (int k = 0; k < 16; k++) m[k % 4][k / 4] = s[127-8*k -: 8];
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        src = enc ? (c + r) % 4 : (c - r + 4) % 4;
        o[127-8*(4*c+r) -: 8] = m[r][src];
      end
    return o;
  endfunction

  task automatic chk_col(input string tag, input logic [31:0] col, input int idx, input logic ctrl);
    chk({tag, " valid"},   128'(bus.col_valid), 128'(1'b1));
    chk({tag, " data"},    128'({bus.A, bus.B, bus.C, bus.D}), 128'(col));
    chk({tag, " idx"},     128'(bus.col_idx), 128'(idx));
    chk({tag, " last"},    128'(bus.col_last), 128'(idx == 3));
    chk({tag, " control"}, 128'(bus.control), 128'(ctrl));
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Called at posedge+1 with the DUT idle; runs one full state with col_ready=1.
  task automatic run_vec(input string tag, input logic [127:0] st, input logic ctl,
                         input logic [127:0] cols);
    bus.in_state = st; bus.in_control = ctl; bus.in_valid = 1'b1; bus.col_ready = 1'b1;
    @(negedge clk); chk({tag, " in_ready idle"}, 128'(bus.in_ready), 128'(1'b1));
    step();
    bus.in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); chk_col(tag, cols[127-32*c -: 32], c, ctl);
      step();
    end
    @(negedge clk); chk({tag, " valid drop"}, 128'(bus.col_valid), 128'(1'b0));
    step();
  endtask

  localparam logic [127:0] ENC_IN  = 128'hd42711ae_e0bf98f1_b8b45de5_1e415230;
  localparam logic [127:0] ENC_OUT = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [127:0] st, so;
    logic ctl, exp_rdy, acc;

    tbl[0] = '{ENC_IN,  1'b1, ENC_OUT};
    tbl[1] = '{ENC_OUT, 1'b0, ENC_IN};
    tbl[2] = '{128'h00010203_04050607_08090a0b_0c0d0e0f, 1'b1,
               128'h00050a0f_04090e03_080d0207_0c01060b};
    tbl[3] = '{128'h00010203_04050607_08090a0b_0c0d0e0f, 1'b0,
               128'h000d0a07_04010e0b_0805020f_0c090603};

    reset = 1'b1; bus.in_valid = 1'b0; bus.in_state = '0; bus.in_control = 1'b0;
    bus.col_ready = 1'b0;
    step(); step();
    @(negedge clk);
    chk("reset in_ready",  128'(bus.in_ready), 128'(1'b0));
    chk("reset col_valid", 128'(bus.col_valid), 128'(1'b0));
    chk("reset data",      128'({bus.A, bus.B, bus.C, bus.D}), 128'(0));
    chk("reset control",   128'(bus.control), 128'(1'b0));
    step();
    reset = 1'b0;

    for (int i = 0; i < 4; i++) run_vec($sformatf("tbl%0d", i), tbl[i].st, tbl[i].ctl, tbl[i].cols);

    // Backpressure at column 1.
    bus.in_state = ENC_IN; bus.in_control = 1'b1; bus.in_valid = 1'b1; bus.col_ready = 1'b1;
    step(); bus.in_valid = 1'b0;
    @(negedge clk); chk_col("bp c0", ENC_OUT[127:96], 0, 1'b1);
    step(); bus.col_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk_col("bp hold", ENC_OUT[95:64], 1, 1'b1);
      chk("bp in_ready", 128'(bus.in_ready), 128'(1'b0));
      step();
    end
    bus.col_ready = 1'b1;
    for (int c = 1; c < 4; c++) begin
      @(negedge clk); chk_col("bp run", ENC_OUT[127-32*c -: 32], c, 1'b1);
      step();
    end
    @(negedge clk); chk("bp valid drop", 128'(bus.col_valid), 128'(1'b0));
    step();

    // Back-to-back: second state offered during column 3.
    bus.in_state = ENC_IN; bus.in_control = 1'b1; bus.in_valid = 1'b1; bus.col_ready = 1'b1;
    step(); bus.in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); chk_col("b2b first", ENC_OUT[127-32*c -: 32], c, 1'b1);
      if (c == 3) chk("b2b in_ready", 128'(bus.in_ready), 128'(1'b1));
      step();
      if (c == 2) begin
        bus.in_state = ENC_OUT; bus.in_control = 1'b0; bus.in_valid = 1'b1;
      end
    end
    bus.in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); chk_col("b2b second", ENC_IN[127-32*c -: 32], c, 1'b0);
      step();
    end
    @(negedge clk); chk("b2b valid drop", 128'(bus.col_valid), 128'(1'b0));
    step();

    // Reset at column 2.
    bus.in_state = ENC_IN; bus.in_control = 1'b1; bus.in_valid = 1'b1; bus.col_ready = 1'b1;
    step(); bus.in_valid = 1'b0;
    step(); step();
    @(negedge clk); chk_col("rst pre", ENC_OUT[63:32], 2, 1'b1);
    step(); reset = 1'b1;
    @(negedge clk); chk("rst in_ready high", 128'(bus.in_ready), 128'(1'b0));
    step(); reset = 1'b0;
    @(negedge clk);
    chk("rst col_valid", 128'(bus.col_valid), 128'(1'b0));
    chk("rst data",      128'({bus.A, bus.B, bus.C, bus.D}), 128'(0));
    chk("rst control",   128'(bus.control), 128'(1'b0));
    chk("rst idx",       128'(bus.col_idx), 128'(0));
    chk("rst last",      128'(bus.col_last), 128'(1'b0));
    chk("rst in_ready",  128'(bus.in_ready), 128'(1'b1));
    step();
    run_vec("post rst", tbl[3].st, tbl[3].ctl, tbl[3].cols);

    // Ignored input pulse mid-stream.
    bus.in_state = ENC_OUT; bus.in_control = 1'b0; bus.in_valid = 1'b1; bus.col_ready = 1'b1;
    step(); bus.in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); chk_col("ign", ENC_IN[127-32*c -: 32], c, 1'b0);
      if (c == 1) chk("ign in_ready", 128'(bus.in_ready), 128'(1'b0));
      step();
      if (c == 0) begin
        bus.in_state = 128'h11111111_22222222_33333333_44444444; bus.in_control = 1'b1;
        bus.in_valid = 1'b1;
      end else bus.in_valid = 1'b0;
    end
    @(negedge clk); chk("ign valid drop", 128'(bus.col_valid), 128'(1'b0));
    step();

    // Randomized traffic against a column queue.
    q.delete();
    for (int i = 0; i < 416; i++) begin
      if (!bus.in_valid && i < 400 && ($urandom % 3) == 0) begin
        st = {$urandom, $urandom, $urandom, $urandom};
        ctl = 1'($urandom % 2);
        bus.in_state = st; bus.in_control = ctl; bus.in_valid = 1'b1;
      end
      bus.col_ready = (i < 400) ? (($urandom % 4) != 0) : 1'b1;
      @(negedge clk);
      exp_rdy = (q.size() == 0) || (q.size() == 1 && bus.col_ready);
      chk("rnd in_ready",  128'(bus.in_ready), 128'(exp_rdy));
      chk("rnd col_valid", 128'(bus.col_valid), 128'(q.size() != 0));
      if (q.size() != 0) chk_col("rnd", q[0].col, int'(q[0].idx), q[0].ctrl);
      @(posedge clk);
      acc = bus.in_valid && exp_rdy;
      if (q.size() != 0 && bus.col_ready) void'(q.pop_front());
      if (acc) begin
        so = ref_shift(bus.in_state, bus.in_control);
        for (int c = 0; c < 4; c++) begin
          e.col = so[127-32*c -: 32]; e.idx = 2'(c); e.last = (c == 3); e.ctrl = bus.in_control;
          q.push_back(e);
        end
      end
      #1;
      if (acc) bus.in_valid = 1'b0;
    end
    chk("rnd drained", 128'(q.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
